alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-003 The block SHALL have parameter MULT_LAT, default 2, multiply execution cycles (>=1).
REQ-004 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  input  NREQ  per-requester operation valid.
REQ-007 The block SHALL have port req_ready  output  NREQ  per-requester accept strobe.
REQ-008 The block SHALL have port req_op  input  NREQ  per-requester opcode (0 = add, 1 = multiply).
REQ-009 The block SHALL have port req_x  input  NREQ*WIDTH  operand x, requester i in bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port req_y  input  NREQ*WIDTH  operand y, same packing as req_x.
REQ-011 The block SHALL have port rsp_valid  output  1  result valid.
REQ-012 The block SHALL have port rsp_ready  input  1  downstream accepts result.
REQ-013 The block SHALL have port rsp_id  output  clog2(NREQ)  index of requester owning the result.
REQ-014 The block SHALL have port rsp_data  output  2*WIDTH  result.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL implement FSM states IDLE, EXEC and RESP; no other reachable states.
REQ-017 In IDLE, the grant SHALL be the first i with req_valid[i]=1, searching upward from rr_ptr and wrapping from NREQ-1 to 0.
REQ-018 req_ready SHALL be combinational, one-hot and asserted only in IDLE, only for the granted index; all zero otherwise.
REQ-019 On a handshake edge (req_valid[g] & req_ready[g]), the block SHALL latch x, y, op and g; set rr_ptr to (g+1) mod NREQ; enter EXEC.
REQ-020 EXEC SHALL last L cycles, L=1 for add and MULT_LAT for multiply, counted by a down-counter loaded on handshake; then enter RESP.
REQ-021 The add result SHALL be the unsigned (WIDTH+1)-bit sum, zero-extended to 2*WIDTH; the multiply result SHALL be the full unsigned 2*WIDTH product.
REQ-022 rsp_valid SHALL rise at edge k+L after handshake edge k; rsp_data and rsp_id SHALL be held stable while rsp_valid=1.
REQ-023 In RESP, the block SHALL hold until rsp_ready=1, then return to IDLE at that edge; rsp_valid drops the same edge.
REQ-024 Requests arriving while busy SHALL be ignored, with no effect on state; requesters hold valid until ready.
REQ-025 Maximum throughput SHALL be one operation per L+2 cycles; no new grant SHALL occur in the cycle the response completes.
REQ-026 A requester deasserting req_valid before its handshake SHALL lose the grant with no side effect; rr_ptr is unchanged.
REQ-027 With all req_valid=0 in IDLE, the FSM and rr_ptr SHALL remain unchanged.
REQ-028 Operand overflow SHALL NOT occur (widths per REQ-021); e.g. x=y=2^WIDTH-1 multiply yields 2^(2*WIDTH) - 2^(WIDTH+1) + 1.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL enter IDLE with rr_ptr=0, exec counter=0, rsp_valid=0, rsp_id=0, rsp_data=0 and busy=0; req_ready follows REQ-018 (grant from index 0).
REQ-030 Reset asserted in EXEC or RESP SHALL abort the operation with no response emitted; the first post-reset grant SHALL start search at index 0.

Verification
REQ-031 Single add: WIDTH=8, req 2 valid, x=200, y=100, op=0, rsp_ready=1 -> req_ready[2] same cycle; rsp_valid 1 edge after handshake; rsp_data=300; rsp_id=2; busy 2 cycles.
REQ-032 Multiply latency: MULT_LAT=2, req 0 x=255, y=255, op=1 -> rsp_valid 2 edges after handshake; rsp_data=65025.
REQ-033 Round-robin fairness: all 4 requesters continuously valid -> grant order 0,1,2,3,0,...; no requester granted twice before the others.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable; req_ready all 0; completion on first rsp_ready=1 edge.
REQ-035 Reset mid-multiply: rst pulsed during EXEC -> no rsp_valid; next grant with req 3 and req 1 valid goes to 1.
REQ-036 Withdrawn request: req 1 valid for 1 cycle while busy, then dropped -> never granted; rr_ptr unchanged.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter in front of a shared add/multiply unit.
// Requesters compete for a single execution slot; the winner's operands are
// latched, executed for 1 (add) or MULT_LAT (multiply) cycles, and the result
// is presented on the response port until the consumer takes it.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. Requesters keep valid and payload stable
// until they see ready. req_ready is combinational, one-hot, and only ever
// offered in IDLE to the round-robin winner. rsp_valid stays high with
// rsp_id/rsp_data stable until the edge where rsp_ready is sampled high.
module alu_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ*WIDTH-1:0]     req_x,
  input  logic [NREQ*WIDTH-1:0]     req_y,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]        rsp_data,
  output logic                      busy,
  output logic [1:0]                dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MULT_LAT + 1);
  localparam int RW  = 2 * WIDTH;
  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [RW-1:0]    rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  // Arbitration signals
  logic [IDW:0]     wrap_shift;
  logic [NREQ-1:0]  rot_valid;
  logic             grant_vld;
  logic [IDW-1:0]   grant_off;
  logic [IDW:0]     grant_sum;
  logic [IDW-1:0]   grant_idx;
  logic             grant_op;
  logic [WIDTH-1:0] grant_x;
  logic [WIDTH-1:0] grant_y;

  logic [RW-1:0]    result;

  // Round-robin search: rotate valids so rr_ptr sits at bit 0, pick the
  // lowest set bit, then rotate the offset back to an absolute index.
  always_comb begin
    wrap_shift = NREQ_W - {1'b0, rr_ptr_q};
    rot_valid  = (req_valid >> rr_ptr_q) | (req_valid << wrap_shift);
    grant_vld  = 1'b0;
    grant_off  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_vld = 1'b1;
        grant_off = IDW'(k);
      end
    end
    grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
    if (grant_sum >= NREQ_W) begin
      grant_idx = IDW'(grant_sum - NREQ_W);
    end else begin
      grant_idx = IDW'(grant_sum);
    end
  end

  // Select the winner's payload from the packed operand buses.
  always_comb begin
    grant_op = 1'b0;
    grant_x  = '0;
    grant_y  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        grant_op = req_op[k];
        grant_x  = req_x[k*WIDTH +: WIDTH];
        grant_y  = req_y[k*WIDTH +: WIDTH];
      end
    end
  end

  // Accept strobe: one-hot on the winner, only while idle.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_vld) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  // Both results are exact in 2*WIDTH bits, so no overflow handling is needed.
  assign result = op_q ? (RW'(x_q) * RW'(y_q)) : (RW'(x_q) + RW'(y_q));

  // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    x_d        = x_q;
    y_d        = y_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        // A grant is always a handshake: ready is only offered to a valid.
        if (grant_vld) begin
          op_d     = grant_op;
          x_d      = grant_x;
          y_d      = grant_y;
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d    = grant_op ? CW'(MULT_LAT) : CW'(1);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d      = '0;
          rsp_data_d = result;
          rsp_id_d   = id_q;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        // No grant this cycle: req_ready is only driven in IDLE.
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic for alu_arbiter.
// A negedge monitor predicts grants and results from the arbitration rules,
// queues expected responses, and checks them when the DUT presents them.
module tb_alu_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MULT_LAT = 2;
  localparam int IDW      = $clog2(NREQ);
  localparam int RW       = 2 * WIDTH;
  localparam int EW       = 32 + IDW + RW;

  // ---------------- clock / reset ----------------
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op = '0;
  logic [NREQ*WIDTH-1:0] req_x = '0;
  logic [NREQ*WIDTH-1:0] req_y = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [RW-1:0]         rsp_data;
  logic                  busy;
  logic [1:0]            dbg_state;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]   exp_q[$];     // {due cycle, id, data}
  int              grant_log[$];
  int              m_ptr = 0;
  logic            rsp_seen = 1'b0;
  logic [NREQ-1:0] hs_mask = '0;
  int              done_cnt = 0;
  logic [RW-1:0]   last_data = '0;
  int              last_id = 0;
  int              errors = 0;
  int              checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First valid requester at or after ptr, wrapping; -1 when none.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- monitor / reference model ----------------
  always @(negedge clk) begin
    int              g;
    int              due;
    longint          res;
    logic [NREQ-1:0] exp_ready;
    logic [EW-1:0]   head;
    hs_mask = '0;
    if (rst) begin
      exp_q.delete();
      m_ptr    = 0;
      rsp_seen = 1'b0;
    end else begin
      check("busy", {63'd0, busy}, {63'd0, exp_q.size() != 0});
      g = (exp_q.size() == 0) ? model_grant(req_valid, m_ptr) : -1;
      exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
      check("req_ready", 64'(req_ready), 64'(exp_ready));

      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_spurious", {63'd0, rsp_valid}, 64'd0);
        end else begin
          head = exp_q[0];
          check("rsp_id", 64'(rsp_id), 64'(head[RW +: IDW]));
          check("rsp_data", 64'(rsp_data), 64'(head[RW-1:0]));
          if (!rsp_seen) check("rsp_latency", 64'(cyc), 64'(head[EW-1 -: 32]));
          rsp_seen = 1'b1;
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_seen  = 1'b0;
            done_cnt++;
            last_data = rsp_data;
            last_id   = int'(rsp_id);
          end
        end
      end else if (exp_q.size() != 0) begin
        head = exp_q[0];
        if (rsp_seen || cyc >= int'(head[EW-1 -: 32])) begin
          check("rsp_valid_missing", {63'd0, rsp_valid}, 64'd1);
          void'(exp_q.pop_front());
          rsp_seen = 1'b0;
        end
      end

      if (g >= 0) begin
        if (req_op[g])
          res = longint'(req_x[g*WIDTH +: WIDTH]) * longint'(req_y[g*WIDTH +: WIDTH]);
        else
          res = longint'(req_x[g*WIDTH +: WIDTH]) + longint'(req_y[g*WIDTH +: WIDTH]);
        due = cyc + 1 + (req_op[g] ? MULT_LAT : 1);
        exp_q.push_back({32'(due), IDW'(g), RW'(res)});
        grant_log.push_back(g);
        m_ptr = (g + 1) % NREQ;
      end
      hs_mask = req_valid & req_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs_mask;
  endtask

  task automatic issue(input int i, input logic op, input logic [WIDTH-1:0] x,
                       input logic [WIDTH-1:0] y);
    req_valid[i]               = 1'b1;
    req_op[i]                  = op;
    req_x[i*WIDTH +: WIDTH]    = x;
    req_y[i*WIDTH +: WIDTH]    = y;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rnd_operand();
    int s = $urandom_range(0, 9);
    if (s == 0) return '0;
    if (s == 1) return '1;
    return WIDTH'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int d0;
    int n;
    int g0;

    repeat (3) tick();
    rst = 1'b0;
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_id", 64'(rsp_id), 64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);

    // Single add on requester 2
    issue(2, 1'b0, 8'd200, 8'd100);
    wait_idle(20);
    check("add_data", 64'(last_data), 64'd300);
    check("add_id", 64'(last_id), 64'd2);

    // Multiply at the operand maximum
    issue(0, 1'b1, 8'd255, 8'd255);
    wait_idle(20);
    check("mul_data", 64'(last_data), 64'd65025);
    check("mul_id", 64'(last_id), 64'd0);

    // Round-robin with every requester continuously valid
    do_reset();
    base = grant_log.size();
    n = 0;
    while (grant_log.size() < base + 8 && n < 200) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i]) issue(i, 1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
      tick();
      n++;
    end
    req_valid = '0;
    wait_idle(30);
    for (int k = 0; k < 8; k++) begin
      if (base + k < grant_log.size())
        check("rr_order", 64'(grant_log[base + k]), 64'(k % NREQ));
      else
        check("rr_order_missing", 64'(grant_log.size()), 64'(base + 8));
    end

    // Backpressure: hold the response for 5 cycles
    rsp_ready = 1'b0;
    issue(1, 1'b0, 8'd17, 8'd34);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    d0 = done_cnt;
    repeat (5) tick();
    check("bp_held_valid", {63'd0, rsp_valid}, 64'd1);
    check("bp_no_completion", 64'(done_cnt), 64'(d0));
    check("bp_ready_zero", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    tick();
    check("bp_completion", 64'(done_cnt), 64'(d0 + 1));
    check("bp_valid_dropped", {63'd0, rsp_valid}, 64'd0);
    check("bp_data", 64'(last_data), 64'd51);
    wait_idle(20);

    // Reset during multiply execution
    issue(0, 1'b1, 8'd200, 8'd3);
    tick();
    tick();
    check("mid_mul_state_exec", 64'(dbg_state), 64'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_no_valid", {63'd0, rsp_valid}, 64'd0);
    base = grant_log.size();
    issue(3, 1'b0, 8'd1, 8'd2);
    issue(1, 1'b0, 8'd3, 8'd4);
    wait_idle(30);
    check("post_reset_grant", 64'(grant_log[base]), 64'd1);
    check("abort_resp_count", 64'(done_cnt), 64'(d0 + 2));

    // Withdrawn request while busy
    g0 = grant_log.size();
    issue(0, 1'b1, 8'd9, 8'd9);
    tick();
    issue(1, 1'b0, 8'd5, 8'd5);
    tick();
    req_valid[1] = 1'b0;
    wait_idle(20);
    check("withdraw_grants", 64'(grant_log.size()), 64'(g0 + 1));
    base = grant_log.size();
    issue(2, 1'b0, 8'd6, 8'd7);
    issue(1, 1'b0, 8'd8, 8'd9);
    wait_idle(30);
    check("withdraw_ptr_kept", 64'(grant_log[base]), 64'd1);

    // Randomized traffic with backpressure and occasional withdrawal
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 99) < 30)
            issue(i, 1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
        end else if ($urandom_range(0, 99) < 3) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
